seq_tx_101: RTL and testbench

Serial pattern transmitter for the "101" sequence-detector family. It accepts a parallel word through a valid/ready handshake and serializes it MSB-first, one bit per clock, optionally repeated. It drives a detector's serial input. It also carries a built-in overlapping-"101" reference tracker, so benches get the expected match pulses and match count alongside the stream.

---
 rtl/seq_tx_101.sv | 120 ++++++++++++
 tb/tb_seq_tx_101.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_tx_101.sv
// Serial "101"-family pattern transmitter: loads a word over valid/ready and shifts it
// out MSB-first rpt+1 times, with an overlapping "101" reference tracker alongside.
module seq_tx_101 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       rpt,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out_seq,
  output logic             out_valid,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = $clog2(4 * WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0]    POS_MSB = PW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  typedef enum logic [1:0] {T0, T1, T2} trk_t;

  state_t           state;
  trk_t             trk;
  logic [WIDTH-1:0] word;
  logic [PW-1:0]    pos;
  logic [RW-1:0]    remaining;

  logic             next_bit;
  logic [PW-1:0]    pos_cur;
  logic [PW-1:0]    pos_step;
  trk_t             trk_in;
  trk_t             trk_next;
  logic             hit;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // The bit emitted on an accept edge comes straight from data_in with a fresh tracker and count.
  always_comb begin
    pos_cur  = (state == IDLE) ? POS_MSB : pos;
    pos_step = (pos_cur == '0) ? POS_MSB : pos_cur - 1'b1;
    next_bit = (state == IDLE) ? data_in[WIDTH-1] : word[pos_cur];
    trk_in   = (state == IDLE) ? T0 : trk;
    cnt_base = (state == IDLE) ? '0 : match_cnt;
    hit      = 1'b0;
    trk_next = T0;
    case (trk_in)
      T0: trk_next = next_bit ? T1 : T0;
      T1: trk_next = next_bit ? T1 : T2;
      T2: begin
        trk_next = next_bit ? T1 : T0;
        hit      = next_bit;
      end
      default: trk_next = T0;
    endcase
    cnt_next = (hit && cnt_base != CNT_MAX) ? cnt_base + 1'b1 : cnt_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      trk         <= T0;
      word        <= '0;
      pos         <= '0;
      remaining   <= '0;
      out_seq     <= 1'b0;
      out_valid   <= 1'b0;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state       <= SEND;
            word        <= data_in;
            remaining   <= RW'(WIDTH * (int'(rpt) + 1) - 1);
            pos         <= pos_step;
            out_seq     <= next_bit;
            out_valid   <= 1'b1;
            match_pulse <= hit;
            trk         <= trk_next;
            match_cnt   <= cnt_next;
          end
        end
        SEND: begin
          if (remaining == '0) begin
            state       <= DONE;
            done        <= 1'b1;
            out_seq     <= 1'b0;
            out_valid   <= 1'b0;
            match_pulse <= 1'b0;
          end else begin
            remaining   <= remaining - 1'b1;
            pos         <= pos_step;
            out_seq     <= next_bit;
            match_pulse <= hit;
            trk         <= trk_next;
            match_cnt   <= cnt_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx_101.sv
// Scoreboard bench for seq_tx_101: two instances (CNT_W=4 and CNT_W=3) share stimulus and are
// checked against a window-based "101" reference computed per accepted frame.
module tb_seq_tx_101;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] data_in;
  logic [1:0] rpt;

  logic       a_ready, a_seq, a_valid, a_pulse, a_busy, a_done;
  logic [3:0] a_cnt;
  logic       b_ready, b_seq, b_valid, b_pulse, b_busy, b_done;
  logic [2:0] b_cnt;

  typedef struct {
    bit b;
    bit p;
    int c4;
    int c3;
  } exp_t;

  exp_t exp_q[$];
  int   m_wait;
  int   m_last4;
  int   m_last3;
  bit   mon_en;
  bit   final_chk;
  int   checks = 0;
  int   errors = 0;

  seq_tx_101 #(.WIDTH(WIDTH), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .rpt(rpt), .load_valid(load_valid),
    .load_ready(a_ready), .out_seq(a_seq), .out_valid(a_valid), .match_pulse(a_pulse),
    .match_cnt(a_cnt), .busy(a_busy), .done(a_done)
  );

  seq_tx_101 #(.WIDTH(WIDTH), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .data_in(data_in), .rpt(rpt), .load_valid(load_valid),
    .load_ready(b_ready), .out_seq(b_seq), .out_valid(b_valid), .match_pulse(b_pulse),
    .match_cnt(b_cnt), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the frame is the word repeated, and a match is any "101" window ending at a bit.
  task automatic push_frame(input logic [7:0] d, input logic [1:0] r);
    bit   bits[$];
    int   n4 = 0;
    int   n3 = 0;
    int   len = WIDTH * (int'(r) + 1);
    bit   hit;
    exp_t e;
    for (int i = 0; i < len; i++) bits.push_back(d[WIDTH-1-(i%WIDTH)]);
    for (int i = 0; i < len; i++) begin
      hit = (i >= 2) && bits[i-2] && !bits[i-1] && bits[i];
      if (hit) begin
        n4 = (n4 < 15) ? n4 + 1 : 15;
        n3 = (n3 < 7) ? n3 + 1 : 7;
      end
      e.b = bits[i];
      e.p = hit;
      e.c4 = n4;
      e.c3 = n3;
      exp_q.push_back(e);
    end
    m_last4 = n4;
    m_last3 = n3;
    m_wait = len + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_wait = 0;
      m_last4 = 0;
      m_last3 = 0;
    end else if (m_wait == 0 && load_valid) begin
      push_frame(data_in, rpt);
    end else if (m_wait > 0) begin
      m_wait--;
    end
    #2;
  endtask

  task automatic applyStimulus(input logic r, input logic lv, input logic [7:0] d, input logic [1:0] rp);
    rst = r;
    load_valid = lv;
    data_in = d;
    rpt = rp;
    tick();
  endtask

  task automatic idle_for(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom), 2'($urandom));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checkOutput("a_load_ready", int'(a_ready), int'(m_wait == 0));
      checkOutput("b_load_ready", int'(b_ready), int'(m_wait == 0));
      checkOutput("a_busy", int'(a_busy), int'(m_wait != 0));
      checkOutput("b_busy", int'(b_busy), int'(m_wait != 0));
      checkOutput("a_done", int'(a_done), int'(m_wait == 1));
      checkOutput("b_done", int'(b_done), int'(m_wait == 1));
      checkOutput("a_out_valid", int'(a_valid), int'(m_wait >= 2));
      checkOutput("b_out_valid", int'(b_valid), int'(m_wait >= 2));
      if (a_valid) begin
        checkOutput("exp_available", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("a_out_seq", int'(a_seq), int'(e.b));
          checkOutput("b_out_seq", int'(b_seq), int'(e.b));
          checkOutput("a_match_pulse", int'(a_pulse), int'(e.p));
          checkOutput("b_match_pulse", int'(b_pulse), int'(e.p));
          checkOutput("a_match_cnt", int'(a_cnt), e.c4);
          checkOutput("b_match_cnt", int'(b_cnt), e.c3);
        end
      end else begin
        checkOutput("a_seq_idle", int'(a_seq), 0);
        checkOutput("b_seq_idle", int'(b_seq), 0);
        checkOutput("a_pulse_idle", int'(a_pulse), 0);
        checkOutput("b_pulse_idle", int'(b_pulse), 0);
        checkOutput("a_cnt_hold", int'(a_cnt), m_last4);
        checkOutput("b_cnt_hold", int'(b_cnt), m_last3);
      end
      if (final_chk) checkOutput("queue_drained", int'(exp_q.size()), 0);
    end
  end

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    data_in = '0;
    rpt = '0;
    m_wait = 0;
    m_last4 = 0;
    m_last3 = 0;
    mon_en = 1'b0;
    final_chk = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();

    $display("[TB] directed frames");
    applyStimulus(1'b0, 1'b1, 8'hAA, 2'd0);
    idle_for(12);
    applyStimulus(1'b0, 1'b1, 8'b10110101, 2'd1);
    idle_for(20);
    applyStimulus(1'b0, 1'b1, 8'b10000010, 2'd1);
    idle_for(20);
    applyStimulus(1'b0, 1'b1, 8'hAA, 2'd3);
    idle_for(36);

    $display("[TB] load_valid held high with data_in changing");
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 2'd0);
    idle_for(12);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 1'b1, 8'hAA, 2'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 2'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0);
    applyStimulus(1'b0, 1'b1, 8'hFF, 2'd0);
    idle_for(12);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++)
      applyStimulus(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                    8'($urandom), 2'($urandom));
    idle_for(40);

    final_chk = 1'b1;
    @(negedge clk);
    #1;
    final_chk = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
